// File: rtl/segment_reader.sv
// Samples a scanned 4-digit 7-segment display, decodes each settled digit phase to BCD and
// publishes complete frames. Define SEGMENT_READER_BLANK_EN to accept a blank digit as zero.
module segment_reader #(
  parameter int unsigned SETTLE  = 16,
  parameter int unsigned TIMEOUT = 2000000
) (
  input  logic        CLOCK,
  input  logic        RESETN,
  input  logic [6:0]  seg_in,
  input  logic [3:0]  an_in,
  output logic [13:0] number,
  output logic [15:0] digits,
  output logic        frame_strobe,
  output logic        frame_valid,
  output logic        pattern_err
);

  localparam int unsigned StW = $clog2(SETTLE);
  localparam logic [StW-1:0] StMax = StW'(SETTLE - 1);
  localparam int unsigned ToW = $clog2(TIMEOUT + 1);
  localparam logic [ToW-1:0] ToMax = ToW'(TIMEOUT);

  logic [10:0]      sync1_q, sync2_q, prev_q;
  logic [StW-1:0]   stab_q, stab_d;
  logic             captured_q, captured_d;
  logic [3:0]       mask_q, mask_d;
  logic [3:0][3:0]  dig_q, dig_d;
  logic [ToW-1:0]   to_q, to_d;
  logic [13:0]      number_q, number_d;
  logic [15:0]      digits_q, digits_d;
  logic             strobe_q, strobe_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  logic             changed, capture, complete, pos_valid;
  logic [1:0]       pos;
  logic [4:0]       dec;

  // Returns {valid, bcd}; segments are active-low in g..a order.
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'b1000000: decode = {1'b1, 4'd0};
      7'b1111001: decode = {1'b1, 4'd1};
      7'b0100100: decode = {1'b1, 4'd2};
      7'b0110000: decode = {1'b1, 4'd3};
      7'b0011001: decode = {1'b1, 4'd4};
      7'b0010010: decode = {1'b1, 4'd5};
      7'b0000010: decode = {1'b1, 4'd6};
      7'b1111000: decode = {1'b1, 4'd7};
      7'b0000000: decode = {1'b1, 4'd8};
      7'b0010000: decode = {1'b1, 4'd9};
`ifdef SEGMENT_READER_BLANK_EN
      7'b1111111: decode = {1'b1, 4'd0};
`endif
      default:    decode = 5'd0;
    endcase
  endfunction

  assign changed  = (sync2_q != prev_q);
  assign complete = (mask_q == 4'b1111);
  assign dec      = decode(sync2_q[6:0]);

  always_comb begin
    pos_valid = 1'b1;
    pos       = 2'd0;
    unique case (sync2_q[10:7])
      4'b1110: pos = 2'd0;
      4'b1101: pos = 2'd1;
      4'b1011: pos = 2'd2;
      4'b0111: pos = 2'd3;
      default: pos_valid = 1'b0;
    endcase
  end

  // Counting stab_d lets the capture land on the same edge the dwell reaches SETTLE cycles.
  always_comb begin
    stab_d = stab_q;
    if (changed) begin
      stab_d = '0;
    end else if (stab_q != StMax) begin
      stab_d = stab_q + StW'(1);
    end
    capture    = !changed && (stab_d == StMax) && !captured_q && pos_valid;
    captured_d = changed ? 1'b0 : (captured_q | capture);
  end

  always_comb begin
    mask_d   = mask_q;
    dig_d    = dig_q;
    number_d = number_q;
    digits_d = digits_q;
    strobe_d = 1'b0;
    err_d    = 1'b0;
    to_d     = (to_q == ToMax) ? to_q : to_q + ToW'(1);
    if (complete) begin
      mask_d   = 4'b0000;
      digits_d = {dig_q[3], dig_q[2], dig_q[1], dig_q[0]};
      number_d = 14'(dig_q[3]) * 14'd1000 + 14'(dig_q[2]) * 14'd100
               + 14'(dig_q[1]) * 14'd10 + 14'(dig_q[0]);
      strobe_d = 1'b1;
      to_d     = '0;
    end
    valid_d = complete ? 1'b1 : ((to_d == ToMax) ? 1'b0 : valid_q);
    if (capture) begin
      if (dec[4]) begin
        dig_d[pos]  = dec[3:0];
        mask_d[pos] = 1'b1;
      end else begin
        err_d  = 1'b1;
        mask_d = 4'b0000;
      end
    end
  end

  always_ff @(posedge CLOCK or negedge RESETN) begin
    if (!RESETN) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      stab_q     <= '0;
      captured_q <= 1'b0;
      mask_q     <= '0;
      dig_q      <= '0;
      to_q       <= '0;
      number_q   <= '0;
      digits_q   <= '0;
      strobe_q   <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      sync1_q    <= {an_in, seg_in};
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      stab_q     <= stab_d;
      captured_q <= captured_d;
      mask_q     <= mask_d;
      dig_q      <= dig_d;
      to_q       <= to_d;
      number_q   <= number_d;
      digits_q   <= digits_d;
      strobe_q   <= strobe_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign number       = number_q;
  assign digits       = digits_q;
  assign frame_strobe = strobe_q;
  assign frame_valid  = valid_q;
  assign pattern_err  = err_q;

endmodule

// File: tb/tb_segment_reader.sv
// Scoreboard bench for segment_reader: expected frames are queued as the scan is driven and
// popped on every frame_strobe.
module tb_segment_reader;

  localparam int unsigned SETTLE  = 16;
  localparam int unsigned TIMEOUT = 100;
  localparam int          DWELL   = 40;

  logic        CLOCK = 1'b0;
  logic        RESETN = 1'b0;
  logic [6:0]  seg_in = 7'h7f;
  logic [3:0]  an_in = 4'hf;
  logic [13:0] number;
  logic [15:0] digits;
  logic        frame_strobe, frame_valid, pattern_err;

  segment_reader #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .CLOCK       (CLOCK),
    .RESETN      (RESETN),
    .seg_in      (seg_in),
    .an_in       (an_in),
    .number      (number),
    .digits      (digits),
    .frame_strobe(frame_strobe),
    .frame_valid (frame_valid),
    .pattern_err (pattern_err)
  );

  always #5 CLOCK = ~CLOCK;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int last_strobe_cyc = 0;
  int strobes = 0;
  int errs = 0;
  int exp_q[$];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  function automatic logic [6:0] enc(input int d);
    case (d)
      0: enc = 7'b1000000;
      1: enc = 7'b1111001;
      2: enc = 7'b0100100;
      3: enc = 7'b0110000;
      4: enc = 7'b0011001;
      5: enc = 7'b0010010;
      6: enc = 7'b0000010;
      7: enc = 7'b1111000;
      8: enc = 7'b0000000;
      9: enc = 7'b0010000;
      default: enc = 7'b1111111;
    endcase
  endfunction

  function automatic int bcd(input int n);
    return (((n / 1000) % 10) << 12) | (((n / 100) % 10) << 8) | (((n / 10) % 10) << 4)
         | (n % 10);
  endfunction

  initial forever begin
    @(posedge CLOCK);
    cyc = cyc + 1;
  end

  // Monitor: pops one expected frame per strobe, counts pattern_err high cycles.
  initial forever begin
    @(negedge CLOCK);
    if (RESETN) begin
      if (pattern_err) errs++;
      if (frame_strobe) begin
        strobes++;
        last_strobe_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 1, 0);
        end else begin
          int n;
          n = exp_q.pop_front();
          check("number", int'(number), n);
          check("digits", int'(digits), bcd(n));
          check("valid_at_strobe", int'(frame_valid), 1);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLOCK);
      #1;
    end
  endtask

  task automatic dwell(input logic [3:0] an, input logic [6:0] seg, input int n);
    an_in  = an;
    seg_in = seg;
    tick(n);
  endtask

  task automatic scan_raw(input logic [6:0] s3, input logic [6:0] s2, input logic [6:0] s1,
                          input logic [6:0] s0);
    dwell(4'b1110, s0, DWELL);
    dwell(4'b1101, s1, DWELL);
    dwell(4'b1011, s2, DWELL);
    dwell(4'b0111, s3, DWELL);
  endtask

  task automatic scan_num(input int n);
    exp_q.push_back(n);
    scan_raw(enc((n / 1000) % 10), enc((n / 100) % 10), enc((n / 10) % 10), enc(n % 10));
  endtask

  initial begin
    int s0, e0;
    tick(3);
    check("rst_number", int'(number), 0);
    check("rst_digits", int'(digits), 0);
    check("rst_strobe", int'(frame_strobe), 0);
    check("rst_valid", int'(frame_valid), 0);
    check("rst_err", int'(pattern_err), 0);
    RESETN = 1'b1;
    tick(3);

    s0 = strobes;
    scan_num(1234);
    an_in = 4'hf;
    tick(5);
    check("strobes_1234", strobes - s0, 1);

    s0 = strobes;
    scan_num(9999);
    scan_num(0);
    tick(5);
    check("strobes_9999_0", strobes - s0, 2);

    // Invalid-pattern glitch shorter than SETTLE, then an all-anodes-high gap.
    s0 = strobes;
    e0 = errs;
    exp_q.push_back(4321);
    dwell(4'b1110, enc(1), DWELL);
    dwell(4'b1101, enc(2), 22);
    dwell(4'b1101, 7'b1110111, 10);
    dwell(4'b1101, enc(2), 8);
    dwell(4'b1111, enc(2), 10);
    dwell(4'b1011, enc(3), DWELL);
    dwell(4'b0111, enc(4), DWELL);
    tick(5);
    check("glitch_strobes", strobes - s0, 1);
    check("glitch_errs", errs - e0, 0);

    // Reset after three of four digits.
    s0 = strobes;
    dwell(4'b1110, enc(5), DWELL);
    dwell(4'b1101, enc(6), DWELL);
    dwell(4'b1011, enc(7), DWELL);
    RESETN = 1'b0;
    #2;
    check("midrst_number", int'(number), 0);
    check("midrst_digits", int'(digits), 0);
    check("midrst_valid", int'(frame_valid), 0);
    check("midrst_strobe", int'(frame_strobe), 0);
    an_in = 4'hf;
    tick(3);
    RESETN = 1'b1;
    tick(30);
    check("midrst_no_strobe", strobes - s0, 0);
    scan_num(8765);
    tick(5);
    check("post_rst_strobes", strobes - s0, 1);

    // Bad hundreds pattern: one error, no strobe, number holds.
    s0 = strobes;
    e0 = errs;
    scan_raw(enc(5), 7'b1110111, enc(7), enc(8));
    check("err_count", errs - e0, 1);
    check("err_no_strobe", strobes - s0, 0);
    check("err_number_hold", int'(number), 8765);
    scan_num(5678);
    check("clean_after_err", strobes - s0, 1);

    // Stop scanning and measure the timeout from the last strobe.
    an_in = 4'hf;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLOCK);
      if (!frame_valid) break;
    end
    check("timeout_valid_low", int'(frame_valid), 0);
    check("timeout_cycles", cyc - last_strobe_cyc, int'(TIMEOUT));
    check("timeout_number_hold", int'(number), 5678);
    check("timeout_digits_hold", int'(digits), 16'h5678);

    RESETN = 1'b0;
    tick(2);
    RESETN = 1'b1;
    tick(5);
    s0 = strobes;
    e0 = errs;
`ifdef SEGMENT_READER_BLANK_EN
    exp_q.push_back(234);
    scan_raw(7'b1111111, enc(2), enc(3), enc(4));
    tick(5);
    check("blank_strobes", strobes - s0, 1);
    check("blank_errs", errs - e0, 0);
`else
    scan_raw(7'b1111111, enc(2), enc(3), enc(4));
    tick(5);
    check("blank_errs", errs - e0, 1);
    check("blank_strobes", strobes - s0, 0);
    check("blank_number", int'(number), 0);
`endif

    check("sb_drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
